wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage directly upstream of the register bank.
- Accepts one retiring instruction per cycle from the execute stage. Loads are issued to data memory through a req/ack handshake; returned data is aligned and sign- or zero-extended.
- Drives the register bank write port (enable_reg, Rd_back, word_back, link_back, set_back, condition_back) and a forwarding tap for the hazard logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream instruction valid.
- ready_out  out  1  stage can accept this cycle.
- alu_result  in  XLEN  ALU result; load byte address; PC for link.
- rd_in  in  5  destination register.
- is_load  in  1  instruction is a load.
- load_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- load_unsigned  in  1  zero-extend instead of sign-extend.
- link_in  in  1  link instruction.
- set_in  in  1  set-on-condition instruction.
- condition_in  in  1  condition result.
- flush  in  1  kill the held instruction.
- dmem_req  out  1  load request.
- dmem_addr  out  XLEN  word-aligned address, alu_result with bits [1:0] forced to 0.
- dmem_ack  in  1  read data valid.
- dmem_rdata  in  XLEN  read word.
- enable_reg  out  1  register bank write strobe.
- Rd_back  out  5  write register.
- word_back  out  XLEN  write data.
- link_back  out  1  link write.
- set_back  out  1  set write.
- condition_back  out  1  condition value.
- fwd_valid  out  1  equals enable_reg AND Rd_back != 0.
- fwd_rd  out  5  equals Rd_back.
- fwd_value  out  XLEN  value actually written: word_back+4 if link_back; zero-extended condition_back if set_back; else word_back.
- misalign_err  out  1  one-cycle pulse.
- retire_count  out  CNT_W  committed instructions.

Behaviour:
- Reset values: all outputs 0, state IDLE, retire_count 0. Reset overrides every other input, including reset during LOAD_WAIT; any later dmem_ack is ignored.
- States:
  - IDLE: nothing held.
  - LOAD_WAIT: load outstanding.
  - COMMIT: write presented this cycle.
- ready_out = 1 in IDLE and COMMIT; 0 in LOAD_WAIT.
- Accept condition: valid_in AND ready_out AND NOT flush. If flush is high in the accept cycle, the incoming instruction is dropped.
- Accepted non-load: the next cycle is COMMIT with enable_reg=1 and outputs taken from the captured inputs. Latency is 1 cycle.
- Back-to-back non-loads commit on consecutive cycles, COMMIT→COMMIT.
- Accepted load:
  - Misaligned cases: half with addr[0]=1, or word with addr[1:0]≠0. The next cycle pulses misalign_err, enable_reg stays 0, no request is made, state goes to IDLE. The instruction is not counted.
  - Otherwise go to LOAD_WAIT and assert dmem_req, holding dmem_addr stable until dmem_ack.
  - On the dmem_ack cycle, deassert dmem_req on the following edge and go to COMMIT.
  - Data extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. Sign- or zero-extend per load_unsigned.
  - Minimum load latency: accept → req (1 cycle) → ack → commit on the next cycle.
- flush while in LOAD_WAIT: set an internal kill flag and keep dmem_req asserted until ack (the handshake is never abandoned). On ack, go to IDLE with no write.
- flush while in COMMIT does not suppress the write already presented.
- When COMMIT is not followed by an accept, state goes to IDLE and enable_reg returns to 0.
- link_back, set_back and condition_back are passed through unchanged; the register bank applies their semantics. fwd_value mirrors that semantics.
- retire_count increments on every enable_reg=1 cycle, including rd=0 writes, and wraps modulo 2^CNT_W.
- rd_in=0 still produces enable_reg=1; the register bank discards the write.

Test Plan:
- Reset, then non-load rd=5, alu_result=0x1234 → one cycle later enable_reg=1, Rd_back=5, word_back=0x1234, fwd_valid=1, retire_count=1.
- Signed byte load at addr 0x103, rdata=0x80FF_00AA, ack after 3 cycles → dmem_addr=0x100, ready_out=0 while waiting; commit word_back=0xFFFF_FF80.
- Unsigned half load at 0x102, rdata=0xBEEF_0000 → word_back=0x0000_BEEF. Half load at 0x101 → misalign_err pulse, no dmem_req, no write, count unchanged.
- Load in LOAD_WAIT, flush asserted, ack 2 cycles later → dmem_req held until ack, enable_reg never asserted, state IDLE.
- Link instruction with alu_result=0x400 → link_back=1, fwd_value=0x404. Set instruction with condition=1 → fwd_value=1.
- Three back-to-back non-loads → enable_reg high for 3 consecutive cycles. Reset asserted mid-LOAD_WAIT → all outputs 0 next cycle and a late ack is ignored.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: load handshake, data extension, register bank write port
// Holds one retiring instruction; loads wait in LOAD_WAIT until dmem_ack.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [4:0]       rd_in,
   input  logic             is_load,
   input  logic [1:0]       load_size,
   input  logic             load_unsigned,
   input  logic             link_in,
   input  logic             set_in,
   input  logic             condition_in,
   input  logic             flush,
   output logic             dmem_req,
   output logic [XLEN-1:0]  dmem_addr,
   input  logic             dmem_ack,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             enable_reg,
   output logic [4:0]       Rd_back,
   output logic [XLEN-1:0]  word_back,
   output logic             link_back,
   output logic             set_back,
   output logic             condition_back,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_value,
   output logic             misalign_err,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   word_q, word_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              link_q, link_d;
   logic              set_q, set_d;
   logic              cond_q, cond_d;
   logic              kill_q, kill_d;
   logic              misalign_q, misalign_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              misaligned;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [XLEN-1:0]   load_data;

   assign ready_out  = !reset && (state_q != LOAD_WAIT);
   assign accept     = valid_in && ready_out && !flush;
   assign misaligned = ((load_size == 2'd1) && alu_result[0]) ||
                       (load_size[1] && (alu_result[1:0] != 2'b00));

   always_comb begin
      byte_v = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'd0:    load_data = uns_q ? {{(XLEN-8){1'b0}}, byte_v}  : {{(XLEN-8){byte_v[7]}}, byte_v};
         2'd1:    load_data = uns_q ? {{(XLEN-16){1'b0}}, half_v} : {{(XLEN-16){half_v[15]}}, half_v};
         default: load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d    = IDLE;
      rd_d       = rd_q;
      word_d     = word_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      link_d     = link_q;
      set_d      = set_q;
      cond_d     = cond_q;
      kill_d     = 1'b0;
      misalign_d = 1'b0;
      if (state_q == LOAD_WAIT) begin
         // A flushed load still completes its handshake; only the write is dropped.
         kill_d = kill_q || flush;
         if (dmem_ack) begin
            state_d = kill_d ? IDLE : COMMIT;
            word_d  = load_data;
         end else begin
            state_d = LOAD_WAIT;
         end
      end else if (accept) begin
         rd_d   = rd_in;
         link_d = link_in;
         set_d  = set_in;
         cond_d = condition_in;
         if (!is_load) begin
            state_d = COMMIT;
            word_d  = alu_result;
         end else if (misaligned) begin
            misalign_d = 1'b1;
         end else begin
            state_d = LOAD_WAIT;
            addr_d  = alu_result;
            size_d  = load_size;
            uns_d   = load_unsigned;
         end
      end
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (state_d == COMMIT)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         link_q     <= 1'b0;
         set_q      <= 1'b0;
         cond_q     <= 1'b0;
         kill_q     <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         link_q     <= link_d;
         set_q      <= set_d;
         cond_q     <= cond_d;
         kill_q     <= kill_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign dmem_req       = (state_q == LOAD_WAIT);
   assign dmem_addr      = {addr_q[XLEN-1:2], 2'b00};
   assign enable_reg     = (state_q == COMMIT);
   assign Rd_back        = rd_q;
   assign word_back      = word_q;
   assign link_back      = link_q;
   assign set_back       = set_q;
   assign condition_back = cond_q;
   assign misalign_err   = misalign_q;
   assign retire_count   = cnt_q;
   assign fwd_valid      = enable_reg && (rd_q != 5'd0);
   assign fwd_rd         = rd_q;
   assign fwd_value      = link_q ? word_q + 32'd4 :
                           set_q  ? {{(XLEN-1){1'b0}}, cond_q} : word_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed plus randomized bench for wb_stage against an arithmetic reference model
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] alu_result;
   logic [4:0]  rd_in;
   logic        is_load;
   logic [1:0]  load_size;
   logic        load_unsigned;
   logic        link_in;
   logic        set_in;
   logic        condition_in;
   logic        flush;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        enable_reg;
   logic [4:0]  Rd_back;
   logic [31:0] word_back;
   logic        link_back;
   logic        set_back;
   logic        condition_back;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_value;
   logic        misalign_err;
   logic [31:0] retire_count;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;

   wb_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
      .alu_result(alu_result), .rd_in(rd_in), .is_load(is_load), .load_size(load_size),
      .load_unsigned(load_unsigned), .link_in(link_in), .set_in(set_in),
      .condition_in(condition_in), .flush(flush), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .enable_reg(enable_reg), .Rd_back(Rd_back),
      .word_back(word_back), .link_back(link_back), .set_back(set_back),
      .condition_back(condition_back), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
      .fwd_value(fwd_value), .misalign_err(misalign_err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                            input logic uns, input logic [31:0] rdata);
      longint v;
      int sh;
      if (size == 2'd0) begin
         sh = (addr % 4) * 8;
         v = (rdata >> sh) % 256;
         if (!uns && v >= 128) v = v - 256;
      end else if (size == 2'd1) begin
         sh = ((addr / 2) % 2) * 16;
         v = (rdata >> sh) % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = rdata;
      end
      return v[31:0];
   endfunction

   function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] size);
      if (size == 2'd1) return (addr % 2) != 0;
      if (size >= 2'd2) return (addr % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [31:0] w, input logic l, input logic s, input logic c);
      if (l) return w + 4;
      if (s) return c ? 32'd1 : 32'd0;
      return w;
   endfunction

   task automatic do_nonload(input logic [4:0] rd, input logic [31:0] alu, input logic l,
                             input logic s, input logic c, input string tag);
      valid_in = 1'b1; is_load = 1'b0; rd_in = rd; alu_result = alu;
      link_in = l; set_in = s; condition_in = c;
      tick();
      valid_in = 1'b0;
      exp_cnt++;
      chk({tag, "_en"}, 32'(enable_reg), 32'd1);
      chk({tag, "_rd"}, 32'(Rd_back), 32'(rd));
      chk({tag, "_word"}, word_back, alu);
      chk({tag, "_flags"}, {29'd0, link_back, set_back, condition_back}, {29'd0, l, s, c});
      chk({tag, "_fwdv"}, 32'(fwd_valid), (rd != 0) ? 32'd1 : 32'd0);
      chk({tag, "_fwdval"}, fwd_value, ref_fwd(alu, l, s, c));
      chk({tag, "_cnt"}, retire_count, 32'(exp_cnt));
      tick();
      chk({tag, "_en_off"}, 32'(enable_reg), 32'd0);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata, input int wait_cyc,
                          input bit do_flush, input string tag);
      logic [31:0] word_addr;
      valid_in = 1'b1; is_load = 1'b1; alu_result = addr; load_size = size;
      load_unsigned = uns; rd_in = rd; link_in = 1'b0; set_in = 1'b0; condition_in = 1'b0;
      tick();
      valid_in = 1'b0; is_load = 1'b0;
      if (ref_misaligned(addr, size)) begin
         chk({tag, "_mis"}, 32'(misalign_err), 32'd1);
         chk({tag, "_mis_req"}, 32'(dmem_req), 32'd0);
         chk({tag, "_mis_en"}, 32'(enable_reg), 32'd0);
         chk({tag, "_mis_cnt"}, retire_count, 32'(exp_cnt));
         tick();
         chk({tag, "_mis_pulse"}, 32'(misalign_err), 32'd0);
      end else begin
         word_addr = addr - (addr % 4);
         chk({tag, "_req"}, 32'(dmem_req), 32'd1);
         chk({tag, "_addr"}, dmem_addr, word_addr);
         chk({tag, "_rdy"}, 32'(ready_out), 32'd0);
         for (int i = 0; i < wait_cyc; i++) begin
            flush = do_flush && (i == 0);
            tick();
            flush = 1'b0;
            chk({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
            chk({tag, "_addr_hold"}, dmem_addr, word_addr);
            chk({tag, "_en_wait"}, 32'(enable_reg), 32'd0);
         end
         dmem_ack = 1'b1; dmem_rdata = rdata;
         tick();
         dmem_ack = 1'b0; dmem_rdata = $urandom;
         chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
         if (do_flush) begin
            chk({tag, "_kill_en"}, 32'(enable_reg), 32'd0);
            chk({tag, "_kill_rdy"}, 32'(ready_out), 32'd1);
            chk({tag, "_kill_cnt"}, retire_count, 32'(exp_cnt));
         end else begin
            exp_cnt++;
            chk({tag, "_en"}, 32'(enable_reg), 32'd1);
            chk({tag, "_rd"}, 32'(Rd_back), 32'(rd));
            chk({tag, "_word"}, word_back, ref_load(addr, size, uns, rdata));
            chk({tag, "_cnt"}, retire_count, 32'(exp_cnt));
         end
         tick();
         chk({tag, "_en_off"}, 32'(enable_reg), 32'd0);
      end
   endtask

   initial begin
      logic [4:0] rd_r;
      logic [31:0] a_r;
      reset = 1'b1; valid_in = 1'b0; alu_result = '0; rd_in = '0; is_load = 1'b0;
      load_size = '0; load_unsigned = 1'b0; link_in = 1'b0; set_in = 1'b0;
      condition_in = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      tick();
      tick();
      chk("rst_en", 32'(enable_reg), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_rdy", 32'(ready_out), 32'd0);
      chk("rst_word", word_back, 32'd0);
      chk("rst_cnt", retire_count, 32'd0);
      chk("rst_mis", 32'(misalign_err), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle_rdy", 32'(ready_out), 32'd1);

      do_nonload(5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, "nl5");
      do_load(32'h103, 2'd0, 1'b0, 5'd7, 32'h80FF_00AA, 3, 1'b0, "lb_s");
      do_load(32'h102, 2'd1, 1'b1, 5'd8, 32'hBEEF_0000, 0, 1'b0, "lhu");
      do_load(32'h101, 2'd1, 1'b0, 5'd9, 32'h0, 0, 1'b0, "lh_mis");
      do_load(32'h200, 2'd2, 1'b0, 5'd10, 32'h1111_2222, 2, 1'b1, "lw_flush");
      do_nonload(5'd31, 32'h400, 1'b1, 1'b0, 1'b0, "link");
      do_nonload(5'd3, 32'h0, 1'b0, 1'b1, 1'b1, "set");
      do_nonload(5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "rd0");

      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; is_load = 1'b0; rd_in = 5'(i + 1); alu_result = 32'(i * 16);
         link_in = 1'b0; set_in = 1'b0;
         tick();
         exp_cnt++;
         chk("b2b_en", 32'(enable_reg), 32'd1);
         chk("b2b_word", word_back, 32'(i * 16));
         chk("b2b_cnt", retire_count, 32'(exp_cnt));
      end
      valid_in = 1'b0;
      tick();
      chk("b2b_end", 32'(enable_reg), 32'd0);

      valid_in = 1'b1; flush = 1'b1; rd_in = 5'd4; alu_result = 32'h55;
      tick();
      valid_in = 1'b0; flush = 1'b0;
      chk("drop_en", 32'(enable_reg), 32'd0);
      chk("drop_cnt", retire_count, 32'(exp_cnt));

      for (int n = 0; n < 40; n++) begin
         rd_r = 5'($urandom);
         a_r = $urandom;
         case ($urandom_range(0, 2))
            0: do_nonload(rd_r, a_r, 1'($urandom), 1'($urandom), 1'($urandom), "r_nl");
            1: do_load(a_r, 2'($urandom), 1'($urandom), rd_r, $urandom, $urandom_range(0, 3), 1'b0, "r_ld");
            default: do_load({a_r[31:2], 2'b00}, 2'($urandom), 1'($urandom), rd_r, $urandom,
                             $urandom_range(1, 3), 1'b1, "r_fl");
         endcase
      end

      valid_in = 1'b1; is_load = 1'b1; load_size = 2'd2; alu_result = 32'h300; rd_in = 5'd6;
      tick();
      valid_in = 1'b0; is_load = 1'b0;
      chk("mid_req", 32'(dmem_req), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = 0;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_en", 32'(enable_reg), 32'd0);
      chk("mid_rst_cnt", retire_count, 32'd0);
      chk("mid_rst_word", word_back, 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      tick();
      dmem_ack = 1'b0;
      chk("late_ack_en", 32'(enable_reg), 32'd0);
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_rdy", 32'(ready_out), 32'd1);
      chk("late_ack_cnt", retire_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
